// File: rtl/fx_log_pkg.sv
// Shared constants and types for the fx_log datapath stages.
// Q16.16 fixed point, 48-bit accumulator for the log10 rescale.
package fx_log_pkg;

  localparam logic [15:0] LOG10E_Q16 = 16'h6F2E;  // log10(e) in Q0.16
  localparam int          Q_W        = 32;
  localparam int          Q_FRAC     = 16;
  localparam int          ACC_W      = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fx_log10_scale.sv
// Converts ln(x) (signed Q16.16) to log10(x) by a 16-step serial shift-add multiply by log10(e).
// Optional build macro: FX_LOG10_ROUND_EN (round half toward +inf on the final load, else truncate).
module fx_log10_scale
  import fx_log_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ln,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_log10
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE; out_valid is high only in DONE and out_log10 is frozen there.

  state_t                    state, state_nxt;
  logic signed [Q_W-1:0]     operand;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic signed [ACC_W-1:0]   addend;
  logic        [ACC_W-1:0]   acc_load;
  logic        [3:0]         cnt;

  function automatic logic [Q_W-1:0] q16_hi(input logic [ACC_W-1:0] a);
    return a[ACC_W-1:Q_FRAC];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = BUSY;
      BUSY:    if (cnt == 4'd15) state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // One partial product per BUSY cycle: operand scaled by 2^cnt when that constant bit is set.
  always_comb begin
    addend  = {{(ACC_W-Q_W){operand[Q_W-1]}}, operand} <<< cnt;
    acc_nxt = LOG10E_Q16[cnt] ? acc + addend : acc;
`ifdef FX_LOG10_ROUND_EN
    acc_load = acc_nxt + 48'h8000;
`else
    acc_load = acc_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand   <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_log10 <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          operand <= in_ln;
          acc     <= '0;
          cnt     <= '0;
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) out_log10 <= q16_hi(acc_load);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_log10_scale.sv
// Scoreboard bench for fx_log10_scale: randomized and directed samples against an arithmetic model.
module tb_fx_log10_scale;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ln;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_log10;

  fx_log10_scale dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ln     (in_ln),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_log10 (out_log10)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          rand_rdy = 0;
  bit          prev_ov = 0;

  // log10(x) = floor(ln(x) * 28462 / 2^16), optionally +0.5 lsb before the floor
  function automatic logic [31:0] ref_log10(input logic [31:0] x);
    longint p;
    p = longint'($signed(x)) * 64'sd28462;
`ifdef FX_LOG10_ROUND_EN
    p = p + 64'sd32768;
`endif
    p = p >>> 16;
    return p[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: present a sample, record expectation at the edge that accepts it
  task automatic send(input logic [31:0] v, input bit keep, output int acc_cyc);
    acc_cyc = -1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_ln    = v;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_log10(v));
        acc_q.push_back(cyc + 1);
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        in_valid = keep;
        in_ln    = $urandom;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!prev_ov) check("latency", 32'(cyc - acc_q[0]), 32'd16);
          check(out_ready ? "result" : "hold_stable", out_log10, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    int a, prev_a, rel;
    logic [31:0] v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ln     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_log10", out_log10,          32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed values: ln e, ln 10, ln 0.5, zero, extremes
    send(32'h0001_0000, 0, a);
    send(32'h0002_4D76, 0, a);
    send(32'hFFFF_4E8E, 0, a);
    send(32'h0000_0000, 0, a);
    send(32'h7FFF_FFFF, 0, a);
    send(32'h8000_0000, 0, a);
    drain("drain_directed");

    // stall with a new sample pending
    out_ready = 1'b0;
    send(32'h0003_0000, 0, a);
    for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_ln    = 32'hFFFE_0000;
    repeat (10) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    rel = cyc;
    send(32'hFFFE_0000, 0, a);
    check("stall_accept_edge", 32'(a - rel), 32'd2);
    drain("drain_stall");

    // reset in the middle of BUSY discards the sample
    send($urandom, 0, a);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("midrst_out_log10", out_log10,          32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (3) @(negedge clk);
    check("midrst_hold", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(32'd0, 0, a);
    drain("drain_reset");

    // random values with random downstream backpressure
    rand_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      v = $urandom;
      if (i % 3 == 0) v = $signed(v) >>> $urandom_range(4, 16);
      send(v, 0, a);
    end
    drain("drain_random");
    rand_rdy = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // back-to-back with in_valid and out_ready held high
    prev_a = -1;
    for (int i = 0; i < 6; i++) begin
      send($urandom, 1, a);
      if (prev_a >= 0) check("b2b_spacing", 32'(a - prev_a), 32'd18);
      prev_a = a;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("drain_b2b");
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
